mem_access_stage: RTL

MEM stage of the 64-bit pipeline. It sits between the EX/MEM register and the MEM_WB register, and drives the data-memory request/acknowledge bus for loads and stores. It performs size/sign handling, stalls the upstream pipeline while an access is outstanding, and presents registered results (load data, ALU result, WB controls, rd) to MEM_WB.

---
 rtl/mem_access_stage.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory req/ack bus, handles size/sign/alignment and stalls.
// Optional build macro MEM_TIMEOUT_EN adds an ack watchdog that aborts after TIMEOUT BUSY cycles.
module mem_access_stage #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] ALU_data,
  input  logic [63:0]       store_data,
  input  logic [2:0]        funct3,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              regwrite,
  input  logic [4:0]        EX_MEM_rd,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata,
  output logic              out_valid,
  output logic [63:0]       rd_data,
  output logic [ADDR_W-1:0] ALU_data_out,
  output logic              MemtoReg_out,
  output logic              regwrite_out,
  output logic [4:0]        MEM_WB_rd,
  output logic              access_err
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [7:0]        wstrb_q, wstrb_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d, mtr_q, mtr_d, rw_q, rw_d;
  logic [4:0]        rd_q, rd_d;

  logic              ov_q, ov_d, err_q, err_d, mtr_out_q, mtr_out_d, rw_out_q, rw_out_d;
  logic [63:0]       rdd_q, rdd_d;
  logic [ADDR_W-1:0] alu_out_q, alu_out_d;
  logic [4:0]        wbrd_q, wbrd_d;

  logic [2:0]  a_in;
  logic        is_mem, illegal, misaligned, bad, start, timeout_hit;
  logic [7:0]  wstrb_in;
  logic [63:0] wdata_in, shifted, load_val;

  assign a_in = ALU_data[2:0];

  always_comb begin
    is_mem     = MemRead | MemWrite;
    illegal    = (MemRead & MemWrite) | (funct3 == 3'b111) | (MemWrite & funct3[2]);
    misaligned = 1'b0;
    wstrb_in   = 8'hFF;
    wdata_in   = store_data;
    case (funct3[1:0])
      2'b00: begin
        wstrb_in = 8'h01 << a_in;
        wdata_in = {8{store_data[7:0]}};
      end
      2'b01: begin
        misaligned = a_in[0];
        wstrb_in   = 8'h03 << a_in;
        wdata_in   = {4{store_data[15:0]}};
      end
      2'b10: begin
        misaligned = |a_in[1:0];
        wstrb_in   = 8'h0F << a_in;
        wdata_in   = {2{store_data[31:0]}};
      end
      default: misaligned = |a_in;
    endcase
    bad   = is_mem & (illegal | misaligned);
    start = is_mem & ~bad;
  end

  always_comb begin
    shifted = mem_rdata >> {addr_q[2:0], 3'b000};
    case (f3_q)
      3'b000:  load_val = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  load_val = shifted;
      3'b100:  load_val = {56'b0, shifted[7:0]};
      3'b101:  load_val = {48'b0, shifted[15:0]};
      3'b110:  load_val = {32'b0, shifted[31:0]};
      default: load_val = '0;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout_hit = (state_q == StBusy) && !mem_ack && (cnt_q == CntW'(TIMEOUT - 1));
  assign cnt_d       = (state_q == StIdle) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    f3_d      = f3_q;
    we_d      = we_q;
    mtr_d     = mtr_q;
    rw_d      = rw_q;
    rd_d      = rd_q;
    ov_d      = 1'b0;
    err_d     = 1'b0;
    rw_out_d  = 1'b0;
    rdd_d     = rdd_q;
    alu_out_d = alu_out_q;
    mtr_out_d = mtr_out_q;
    wbrd_d    = wbrd_q;
    case (state_q)
      StIdle: begin
        if (in_valid && start) begin
          state_d = StBusy;
          addr_d  = ALU_data;
          wdata_d = wdata_in;
          wstrb_d = wstrb_in;
          f3_d    = funct3;
          we_d    = MemWrite;
          mtr_d   = MemtoReg;
          rw_d    = regwrite;
          rd_d    = EX_MEM_rd;
        end else if (in_valid) begin
          // Non-memory op or rejected access completes in one cycle.
          ov_d      = 1'b1;
          err_d     = bad;
          rw_out_d  = regwrite & ~bad;
          rdd_d     = '0;
          alu_out_d = ALU_data;
          mtr_out_d = MemtoReg;
          wbrd_d    = EX_MEM_rd;
        end
      end
      StBusy: begin
        if (mem_ack || timeout_hit) begin
          state_d   = StIdle;
          ov_d      = 1'b1;
          err_d     = ~mem_ack;
          rw_out_d  = rw_q & mem_ack;
          rdd_d     = (we_q || !mem_ack) ? '0 : load_val;
          alu_out_d = addr_q;
          mtr_out_d = mtr_q;
          wbrd_d    = rd_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      f3_q      <= '0;
      we_q      <= 1'b0;
      mtr_q     <= 1'b0;
      rw_q      <= 1'b0;
      rd_q      <= '0;
      ov_q      <= 1'b0;
      err_q     <= 1'b0;
      rw_out_q  <= 1'b0;
      rdd_q     <= '0;
      alu_out_q <= '0;
      mtr_out_q <= 1'b0;
      wbrd_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      f3_q      <= f3_d;
      we_q      <= we_d;
      mtr_q     <= mtr_d;
      rw_q      <= rw_d;
      rd_q      <= rd_d;
      ov_q      <= ov_d;
      err_q     <= err_d;
      rw_out_q  <= rw_out_d;
      rdd_q     <= rdd_d;
      alu_out_q <= alu_out_d;
      mtr_out_q <= mtr_out_d;
      wbrd_q    <= wbrd_d;
    end
  end

  // Stall is gated by reset so every output reads 0 while reset is held.
  assign stall        = rst & ((state_q == StBusy) | (in_valid & start));
  assign mem_req      = (state_q == StBusy);
  assign mem_we       = (state_q == StBusy) & we_q;
  assign mem_addr     = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem_wdata    = wdata_q;
  assign mem_wstrb    = wstrb_q;
  assign out_valid    = ov_q;
  assign rd_data      = rdd_q;
  assign ALU_data_out = alu_out_q;
  assign MemtoReg_out = mtr_out_q;
  assign regwrite_out = rw_out_q;
  assign MEM_WB_rd    = wbrd_q;
  assign access_err   = err_q;

endmodule
